// File: rtl/fetch_sequencer_if.sv
// Hazard inputs and pipeline-control outputs exchanged between the IF-stage
// sequencer (slave) and the surrounding pipeline (master).
interface fetch_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ex_mem_pcsrc;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rt;
  logic [31:0]      if_id_instr;
  logic             resume;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ex_mem_pcsrc, id_ex_memread, id_ex_rt, if_id_instr, resume,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
    input  state, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ex_mem_pcsrc, id_ex_memread, id_ex_rt, if_id_instr, resume,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
    output state, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: boot hold, load-use stalls, branch flushes and
// HALT drain/resume, with saturating stall and flush event counters.
module fetch_sequencer #(
  parameter int unsigned BOOT_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [5:0]  HALT_OP      = 6'b111111,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam int unsigned MAX_CYC = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int unsigned SEQ_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [SEQ_W-1:0] BOOT_LAST  = SEQ_W'(BOOT_CYCLES - 1);
  localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [4:0] rs, rt;
  logic       hazard, halt_det;
  logic       unused_imm;

  assign rs         = bus.if_id_instr[25:21];
  assign rt         = bus.if_id_instr[20:16];
  assign hazard     = bus.id_ex_memread && (bus.id_ex_rt != 5'd0) &&
                      ((bus.id_ex_rt == rs) || (bus.id_ex_rt == rt));
  assign halt_det   = (bus.if_id_instr[31:26] == HALT_OP);
  assign unused_imm = ^bus.if_id_instr[15:0];

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (seq_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.ex_mem_pcsrc) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_cnt_d  = sat_inc(flush_cnt_q);
        end else if (hazard) begin
          id_ex_flush = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (halt_det) begin
          id_ex_flush = 1'b1;
          state_d     = ST_DRAIN;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      ST_DRAIN: begin
        // An older taken branch still in EX/MEM squashes the pending HALT.
        if (bus.ex_mem_pcsrc) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_cnt_d  = sat_inc(flush_cnt_q);
          state_d      = ST_RUN;
        end else begin
          id_ex_flush = 1'b1;
          if (seq_q == DRAIN_LAST) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (bus.resume) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (state_d != state_q)
      seq_d = '0;
    else if ((state_q == ST_BOOT) || (state_q == ST_DRAIN))
      seq_d = seq_q + SEQ_W'(1);
    else
      seq_d = seq_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      seq_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.halted       = halted;
  assign bus.state        = state_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
